// File: rtl/uop_queue_pkg.sv
// Shared micro-op definitions for the translator-to-RF micro-op queue.
// Field positions describe the 39-bit micro-op word.
package uop_queue_pkg;

    localparam int UOP_W = 39;

    localparam int PCCTL_HI  = 38;
    localparam int PCCTL_LO  = 36;
    localparam int FMASK_HI  = 35;
    localparam int FMASK_LO  = 28;
    localparam int EOI_BIT   = 27;
    localparam int OPCODE_HI = 26;
    localparam int OPCODE_LO = 21;

    localparam logic [5:0] OP_NOP = 6'd0;

    // All-zero word: NOP opcode, no PC control, EOI clear.
    localparam logic [UOP_W-1:0] UOP_NOP = '0;

    typedef struct packed {
        logic [2:0]  pc_ctl;
        logic [7:0]  fmask;
        logic        eoi;
        logic [5:0]  opcode;
        logic [20:0] rest;
    } uop_t;

    function automatic logic uop_is_eoi(input logic [UOP_W-1:0] u);
        return u[EOI_BIT];
    endfunction

endpackage

// File: rtl/uop_queue_mem.sv
// Micro-op storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the controller hides them while empty.
module uop_queue_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 39,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uop_queue.sv
// Circular micro-op queue between the translator and the RF stage.
// Flush and reset empty it; output is a NOP whenever it is empty.
module uop_queue
    import uop_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int UOP_W = uop_queue_pkg::UOP_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [UOP_W-1:0] enq_uop,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic             pipe_stall,
    input  logic             flush,
    output logic [UOP_W-1:0] Iword,
    output logic             uop_valid,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [UOP_W-1:0] rdata;
    logic             do_enq;
    logic             do_deq;

    assign enq_ready = (count != FULL);
    assign uop_valid = (count != '0);
    assign do_enq    = enq_valid && enq_ready && !flush;
    assign do_deq    = uop_valid && !pipe_stall && !flush;

    // Pointer width equals log2(DEPTH), so the increment wraps by itself.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    uop_queue_mem #(
        .DEPTH (DEPTH),
        .W     (UOP_W)
    ) u_mem (
        .CLK   (CLK),
        .we    (do_enq),
        .waddr (wr_ptr),
        .wdata (enq_uop),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign Iword = uop_valid ? rdata : UOP_W'(UOP_NOP);

endmodule
